// File: rtl/rs232_pkg.sv
// Shared types and helpers for the RS-232 transmit/receive path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rs232_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Parity over up to 9 data bits; unused high bits must be zero so they
    // do not disturb the XOR reduction.
    function automatic logic parity_of(input logic [8:0] data, input int unsigned mode);
        parity_of = (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/rs232_tx_framer_if.sv
// Host-side word handshake plus serial line and status of the RS-232 framer.
// Latency: n/a (signal bundle only).
// Backpressure: in_ready gates in_valid; a word moves only when both are 1.
interface rs232_tx_framer_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 tx;
    logic                 busy;
    logic                 start_pulse;
    logic                 stop_pulse;

    // Host / byte source side.
    modport master (
        output in_data, in_valid,
        input  in_ready, tx, busy, start_pulse, stop_pulse
    );

    // Framer side.
    modport slave (
        input  in_data, in_valid,
        output in_ready, tx, busy, start_pulse, stop_pulse
    );
endinterface

// File: rtl/rs232_baud_cnt.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the final clock of each bit.
// Latency: bit_done is high during the last clock of every bit period.
// Backpressure: none; clear holds the count at zero.
module rs232_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_done,
    // high when the count loaded at the next edge is the terminal one, so
    // callers can register a strobe that lines up with bit_done
    output logic next_done
);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: wrap at the terminal value, forced to zero while cleared.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == TERM)) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done  = (cnt_q == TERM);
    assign next_done = (cnt_d == TERM);

endmodule

// File: rtl/rs232_tx_framer.sv
// Serialises words into start / LSB-first data / optional parity / stop-bit frames.
// Latency: start bit appears on tx one clock after the accepting edge.
// Backpressure: in_ready only in IDLE and in the final clock of the last stop bit.
module rs232_tx_framer
    import rs232_pkg::*;
#(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input logic             clk,
    input logic             rst_n,
    rs232_tx_framer_if.slave bus
);
    if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
        $error("rs232_tx_framer: DATA_BITS must be 5..9");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop_bits
        $error("rs232_tx_framer: STOP_BITS must be 1 or 2");
    end
    if (PARITY > PAR_ODD) begin : g_bad_parity
        $error("rs232_tx_framer: PARITY must be 0, 1 or 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_clks
        $error("rs232_tx_framer: CLKS_PER_BIT must be at least 1");
    end

    localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic       HAS_PAR   = (PARITY != PAR_NONE);
    localparam logic       ONE_STOP  = (STOP_BITS == 1);

    tx_state_t            state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [3:0]           bit_idx_q;
    logic                 stop_idx_q;
    logic                 par_q;
    logic                 tx_q;
    logic                 busy_q;
    logic                 start_pulse_q;
    logic                 stop_pulse_q;

    logic bit_done;
    logic next_done;
    logic last_stop_cycle;
    logic accept;
    logic enter_final_stop;
    logic stop_pulse_d;

    // Counter is parked at zero in IDLE, so every START begins on a fresh bit;
    // all other state entries coincide with a natural wrap.
    rs232_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state_q == IDLE),
        .bit_done (bit_done),
        .next_done(next_done)
    );

    // Ready depends only on registered state, never on in_valid.
    assign last_stop_cycle = (state_q == STOP) && bit_done && (stop_idx_q == LAST_STOP);
    assign bus.in_ready    = (state_q == IDLE) || last_stop_cycle;
    assign accept          = bus.in_valid && bus.in_ready;

    // Predict the final clock of the last stop bit one cycle early so the
    // pulse can come straight from a flop.
    always_comb begin
        enter_final_stop = 1'b0;
        case (state_q)
            DATA:    enter_final_stop = (bit_idx_q == LAST_BIT) && !HAS_PAR && ONE_STOP;
            PAR:     enter_final_stop = ONE_STOP;
            STOP:    enter_final_stop = (stop_idx_q != LAST_STOP);
            default: enter_final_stop = 1'b0;
        endcase
        stop_pulse_d = next_done &&
                       ((bit_done && enter_final_stop) ||
                        (!bit_done && (state_q == STOP) && (stop_idx_q == LAST_STOP)));
    end

    // Frame sequencer with registered line and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            bit_idx_q     <= '0;
            stop_idx_q    <= 1'b0;
            par_q         <= 1'b0;
            tx_q          <= 1'b1;
            busy_q        <= 1'b0;
            start_pulse_q <= 1'b0;
            stop_pulse_q  <= 1'b0;
        end else begin
            start_pulse_q <= 1'b0;
            stop_pulse_q  <= stop_pulse_d;
            if (accept) begin
                // Taken from IDLE or from the last stop clock (back-to-back).
                state_q       <= START;
                shift_q       <= bus.in_data;
                par_q         <= parity_of(9'(bus.in_data), PARITY);
                bit_idx_q     <= '0;
                tx_q          <= 1'b0;
                busy_q        <= 1'b1;
                start_pulse_q <= 1'b1;
            end else if (bit_done) begin
                case (state_q)
                    START: begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                    DATA: begin
                        if (bit_idx_q == LAST_BIT) begin
                            if (HAS_PAR) begin
                                state_q <= PAR;
                                tx_q    <= par_q;
                            end else begin
                                state_q    <= STOP;
                                stop_idx_q <= 1'b0;
                                tx_q       <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + 4'd1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                        end
                    end
                    PAR: begin
                        state_q    <= STOP;
                        stop_idx_q <= 1'b0;
                        tx_q       <= 1'b1;
                    end
                    STOP: begin
                        if (stop_idx_q == LAST_STOP) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            tx_q    <= 1'b1;
                        end else begin
                            stop_idx_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.tx          = tx_q;
    assign bus.busy        = busy_q;
    assign bus.start_pulse = start_pulse_q;
    assign bus.stop_pulse  = stop_pulse_q;

endmodule

// File: tb/tb_rs232_tx_framer.sv
// Directed bench over four framer configurations sharing one clock and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_rs232_tx_framer;

    logic clk;
    logic rst_n;

    int vecs  = 0;
    int fails = 0;

    // A: 8 bits, 4 clk/bit, even, 1 stop   B: same, odd parity
    // C: same, no parity                   D: 5 bits, 1 clk/bit, none, 2 stop
    rs232_tx_framer_if #(.DATA_BITS(8)) ifa ();
    rs232_tx_framer_if #(.DATA_BITS(8)) ifb ();
    rs232_tx_framer_if #(.DATA_BITS(8)) ifc ();
    rs232_tx_framer_if #(.DATA_BITS(5)) ifd ();

    rs232_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    rs232_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    rs232_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
    rs232_tx_framer #(.DATA_BITS(5), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2))
        dut_d (.clk(clk), .rst_n(rst_n), .bus(ifd));

    logic       vld [4];
    logic [8:0] dat [4];
    logic       tx_w [4];
    logic       busy_w [4];
    logic       rdy_w [4];
    logic       start_w [4];
    logic       stop_w [4];

    assign ifa.in_valid = vld[0];
    assign ifb.in_valid = vld[1];
    assign ifc.in_valid = vld[2];
    assign ifd.in_valid = vld[3];
    assign ifa.in_data  = dat[0][7:0];
    assign ifb.in_data  = dat[1][7:0];
    assign ifc.in_data  = dat[2][7:0];
    assign ifd.in_data  = dat[3][4:0];

    assign tx_w[0] = ifa.tx;          assign tx_w[1] = ifb.tx;
    assign tx_w[2] = ifc.tx;          assign tx_w[3] = ifd.tx;
    assign busy_w[0] = ifa.busy;      assign busy_w[1] = ifb.busy;
    assign busy_w[2] = ifc.busy;      assign busy_w[3] = ifd.busy;
    assign rdy_w[0] = ifa.in_ready;   assign rdy_w[1] = ifb.in_ready;
    assign rdy_w[2] = ifc.in_ready;   assign rdy_w[3] = ifd.in_ready;
    assign start_w[0] = ifa.start_pulse;  assign start_w[1] = ifb.start_pulse;
    assign start_w[2] = ifc.start_pulse;  assign start_w[3] = ifd.start_pulse;
    assign stop_w[0] = ifa.stop_pulse;    assign stop_w[1] = ifb.stop_pulse;
    assign stop_w[2] = ifc.stop_pulse;    assign stop_w[3] = ifd.stop_pulse;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends d0 (and d1 back-to-back when nfr==2) on instance k and watches
    // nbits*cpb clocks of line activity. bits holds the hand-derived line
    // level of each bit slot, first slot in bit 0. glitch>=0 raises in_valid
    // for one clock at that frame cycle, when the framer must ignore it.
    task automatic run_frame(input int k, input logic [8:0] d0, input logic [8:0] d1,
                             input int nfr, input int cpb, input int nbits,
                             input logic [31:0] bits, input int glitch, input string tag);
        int ncyc;
        logic [127:0] got;
        logic [127:0] exp;
        logic all_busy;
        logic rdy_now;
        int n_start;
        int n_stop;
        int n_rdy;
        int last_start;
        int last_stop;
        ncyc = nbits * cpb;
        got = '0;
        exp = '0;
        all_busy = 1'b1;
        n_start = 0;
        n_stop = 0;
        n_rdy = 0;
        last_start = -1;
        last_stop = -1;
        @(negedge clk);
        chk({tag, " ready_idle"}, 128'(rdy_w[k]), 128'(1));
        vld[k] = 1'b1;
        dat[k] = d0;
        @(negedge clk);
        dat[k] = d1;
        if (nfr == 1) vld[k] = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            if (glitch >= 0) vld[k] = (i == glitch);
            got[i] = tx_w[k];
            exp[i] = bits[i / cpb];
            all_busy = all_busy & busy_w[k];
            if (start_w[k]) begin n_start++; last_start = i; end
            if (stop_w[k])  begin n_stop++;  last_stop = i;  end
            rdy_now = rdy_w[k];
            if (rdy_now) n_rdy++;
            @(negedge clk);
            if (rdy_now && (glitch < 0)) vld[k] = 1'b0;
        end
        vld[k] = 1'b0;
        chk({tag, " tx_seq"},     got, exp);
        chk({tag, " busy_held"},  128'(all_busy), 128'(1));
        chk({tag, " n_start"},    128'(n_start), 128'(nfr));
        chk({tag, " last_start"}, 128'(last_start), 128'((nfr - 1) * ncyc / nfr));
        chk({tag, " n_stop"},     128'(n_stop), 128'(nfr));
        chk({tag, " stop_pos"},   128'(last_stop), 128'(ncyc - 1));
        chk({tag, " n_ready"},    128'(n_rdy), 128'(nfr));
        chk({tag, " tx_after"},   128'(tx_w[k]), 128'(1));
        chk({tag, " busy_after"}, 128'(busy_w[k]), 128'(0));
        chk({tag, " rdy_after"},  128'(rdy_w[k]), 128'(1));
    endtask

    int n_sp;
    int n_low;

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vld[k] = 1'b0;
            dat[k] = '0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst tx",    128'(tx_w[k]),    128'(1));
            chk("rst busy",  128'(busy_w[k]),  128'(0));
            chk("rst ready", 128'(rdy_w[k]),   128'(1));
            chk("rst start", 128'(start_w[k]), 128'(0));
            chk("rst stop",  128'(stop_w[k]),  128'(0));
        end
        rst_n = 1'b1;

        // 0xA5 even: 0 | 1 0 1 0 0 1 0 1 | par 0 | 1
        run_frame(0, 9'h0A5, 9'h05A, 1, 4, 11, 32'h0000_054A, -1, "A5_even");
        // 0x07 odd: 0 | 1 1 1 0 0 0 0 0 | par 0 | 1
        run_frame(1, 9'h007, 9'h0F8, 1, 4, 11, 32'h0000_040E, -1, "07_odd");
        // 0x07 even: parity 1; stray in_valid mid-frame must be ignored
        run_frame(0, 9'h007, 9'h0FF, 1, 4, 11, 32'h0000_060E, 20, "07_even_glitch");
        // 0x3C no parity: 0 | 0 0 1 1 1 1 0 0 | 1  (40 clocks)
        run_frame(2, 9'h03C, 9'h0C3, 1, 4, 10, 32'h0000_0278, -1, "3C_none");
        // back-to-back 0x55 then 0xAA, even parity, parity bit 0 for both
        run_frame(0, 9'h055, 9'h0AA, 2, 4, 22, (32'h554 << 11) | 32'h4AA, -1, "b2b");
        // 5 bits, 2 stop, one clock per bit: 0 1 1 1 1 1 1 1
        run_frame(3, 9'h01F, 9'h000, 1, 1, 8, 32'h0000_00FE, -1, "D_1F");

        // reset ten clocks into a frame
        @(negedge clk);
        vld[0] = 1'b1;
        dat[0] = 9'h0A5;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst in_frame", 128'(busy_w[0]), 128'(1));
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst tx",    128'(tx_w[0]),   128'(1));
        chk("midrst busy",  128'(busy_w[0]), 128'(0));
        chk("midrst ready", 128'(rdy_w[0]),  128'(1));
        chk("midrst stop",  128'(stop_w[0]), 128'(0));
        rst_n = 1'b1;
        n_sp = 0;
        n_low = 0;
        for (int i = 0; i < 50; i++) begin
            if (stop_w[0]) n_sp++;
            if (!tx_w[0]) n_low++;
            @(negedge clk);
        end
        chk("midrst no_stop_pulse", 128'(n_sp), 128'(0));
        chk("midrst line_idle",     128'(n_low), 128'(0));
        run_frame(0, 9'h0A5, 9'h000, 1, 4, 11, 32'h0000_054A, -1, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/rs232_tx_framer.md
# rs232_tx_framer

Parametrised RS-232 serial transmitter: accepts parallel words over a valid/ready handshake and serialises each into an asynchronous frame. A frame is a start bit, DATA_BITS data bits LSB-first, an optional parity bit, and 1 or 2 stop bits, each held for CLKS_PER_BIT clocks. It is the configurable successor to the fixed 8-bit, one-bit-per-clock transmitter and sits between the host-side byte source and the line driver (RS-232/RS-422 PHY).

## Interface
- DATA_BITS, default 8: data bits per frame; legal range 5–9.
- CLKS_PER_BIT, default 16: clocks per serial bit; must be ≥1.
- PARITY, default 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, default 1: 1 or 2.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_data  in  DATA_BITS  word to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- tx  out  1  serial line; idle/mark = 1.
- busy  out  1  frame in progress.
- start_pulse  out  1  one-cycle pulse on the first cycle of each start bit.
- stop_pulse  out  1  one-cycle pulse on the last cycle of each frame's final stop bit.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- Transfer: a word is accepted when in_valid && in_ready on a rising edge. in_data is captured into a shift register. Parity is computed from the captured word: even = XOR of data bits; odd = inverted XOR.
- IDLE: tx=1, busy=0, in_ready=1. On accept, go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: shift out the LSB first; each bit lasts CLKS_PER_BIT cycles. Bit index runs 0..DATA_BITS-1. After the last bit, go to PAR if PARITY≠0, else STOP.
- PAR: tx=parity bit for CLKS_PER_BIT cycles, then go to STOP.
- STOP: tx=1 for STOP_BITS×CLKS_PER_BIT cycles.
- End of STOP, with no accept: go to IDLE.
- In-frame acceptance: in_ready is also 1 during the final cycle of the last stop bit. An accept in that cycle goes directly to START, so frames run back-to-back with no gap.
- in_ready is 0 in every other non-IDLE cycle. in_valid is ignored while in_ready=0.
- in_data changes after acceptance have no effect on the frame in flight.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. It is reset to 0 on every state entry.
- Width: $clog2(CLKS_PER_BIT) bits, minimum 1. CLKS_PER_BIT=1 must work, giving one bit per clock.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.

## Timing
- Reset values (rst_n=0 on an edge): state=IDLE, tx=1, busy=0, in_ready=1, start_pulse=0, stop_pulse=0, counters=0, shift register=0.
- Reset mid-frame: the frame is abandoned. tx=1 on the next edge, and no stop_pulse is produced.
- All outputs are registered. tx, busy and start_pulse change on the edge after the accepting edge, so there is 1 clock of latency from accept to the start bit.
- busy is 1 from the first START cycle through the last STOP cycle. It stays 1 across back-to-back frames.
- The in_ready cycle during the last stop bit is combinationally derived from registered state and counters. There is no dependence on in_valid, so no combinational path from in_valid to in_ready.
- Illegal parameters (DATA_BITS outside 5–9, STOP_BITS∉{1,2}, PARITY>2, CLKS_PER_BIT<1) trigger an elaboration-time error.

## Structure
- Package rs232_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PAR, STOP);
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - the shared parity function.
- One sub-module, rs232_baud_cnt (parameter CLKS_PER_BIT; inputs clk, rst_n, clear; output bit_done), produces the end-of-bit strobe. The future receiver reuses it.

## Test plan
- DATA_BITS=8, CLKS_PER_BIT=4, PARITY=even, STOP_BITS=1; send 0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,0(par),1, each bit held 4 cycles; 44-cycle frame; one start_pulse and one stop_pulse.
- PARITY=odd, send 0x07 → parity bit 0. PARITY=even, send 0x07 → parity bit 1. PARITY=none → no parity slot; frame 40 cycles at CLKS_PER_BIT=4.
- Back-to-back: in_valid held high with 0x55 then 0xAA → second start bit begins on the cycle immediately after the first frame's last stop cycle; busy never drops; in_ready high for exactly 1 cycle per frame.
- DATA_BITS=5, STOP_BITS=2, CLKS_PER_BIT=1; send 5'h1F → tx 0,1,1,1,1,1,1,1; 8-cycle frame.
- Reset asserted at cycle 10 of a frame → next edge: tx=1, busy=0, in_ready=1; no stop_pulse; the next accepted word produces a clean full frame.
- in_valid pulsed while busy (not in the last stop cycle) → word ignored, no extra frame, tx unaffected.
